llc_input_select: RTL and testbench
===================================

# llc_input_select

Downstream stage of the LLC input bypass queues. Takes the four buffered message channels (coherence response, testbench reset, CPU request, DMA request), picks one per transaction by fixed priority, and hands it to the LLC core over a single registered valid/ready port. It never asserts any `*_ready_int` as a combinational function of any `*_valid_int`, so it cannot form a loop with the upstream bypass mux.

## Interface
Parameters: none. All widths come from the shared cache package.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rsp_valid_int` in 1 / `rsp_ready_int` out 1 / `rsp_next` in `llc_rsp_in_t`: response channel.
- `rst_tb_valid_int` in 1 / `rst_tb_ready_int` out 1 / `rst_tb_next` in 1: testbench-reset channel.
- `req_valid_int` in 1 / `req_ready_int` out 1 / `req_next` in `llc_req_in_t`: CPU request channel.
- `dma_req_valid_int` in 1 / `dma_req_ready_int` out 1 / `dma_req_next` in `llc_req_in_t`: DMA request channel.
- `recall_pending` in 1: core is waiting on a recall. While high, only the rsp channel is eligible.
- `sel_valid` out 1 / `sel_ready` in 1: port to the core.
- `sel_src` out `llc_in_src_t`: `SRC_RSP`, `SRC_RST_TB`, `SRC_REQ`, or `SRC_DMA`.
- `sel_req` out `llc_req_in_t`, `sel_rsp` out `llc_rsp_in_t`, `sel_rst_tb` out 1: selected payload. Fields unrelated to `sel_src` hold their previous values.

## Operation
- FSM states: SCAN, GRANT, FULL. Reset state is SCAN.
- SCAN
  - All `*_ready_int` are 0.
  - Eligible set = valid channels, masked to rsp only when `recall_pending`=1.
  - If the set is non-empty, register the winner in `grant` and go to GRANT. Otherwise stay in SCAN.
- Priority: rsp > rst_tb > (req vs dma).
  - req beats dma unless the round-robin feature is enabled.
- GRANT
  - Assert exactly the granted channel's `*_ready_int` for one cycle.
  - Capture its payload into the `sel_*` registers. Set `sel_src` = grant and `sel_valid` = 1.
  - Go to FULL.
  - The granted channel's valid_int stays high through GRANT because upstream parked it during SCAN. If it is found low, do not capture, do not set `sel_valid`, and return to SCAN.
- FULL
  - All `*_ready_int` are 0.
  - Hold `sel_valid`=1 and stable payload until `sel_ready`=1.
  - On that handshake, clear `sel_valid` and go to SCAN.
- `recall_pending` is sampled only in SCAN. A grant already taken completes even if `recall_pending` rises later.
- Simultaneous valid on all channels: rsp always wins; the others stay parked upstream.
- Reset mid-operation clears `sel_valid` and `grant`. A message captured but not yet handshaken is dropped; upstream re-offers nothing. This is acceptable only under global reset.

## Timing
- Reset values: `sel_valid`=0, all `*_ready_int`=0, `sel_src`=`SRC_RSP`, all payload fields 0, `rr_last_dma`=0.
- Latency: a channel valid in SCAN in cycle N gives `ready_int` in N+1 and `sel_valid` from N+2.
- Minimum transaction period: 3 cycles (SCAN, GRANT, FULL with `sel_ready` already high).
- `sel_valid` is registered. Payload is stable for the whole time `sel_valid` is high.
- Every GRANT is followed by at least one cycle with all `ready_int`=0. This guarantees upstream parking state is refreshed before the next SCAN.
- `*_ready_int` depends only on the FSM state and `grant` registers, never on any input combinationally.

## Configuration
- Macro `LLC_DMA_RR_EN`.
- Defined:
  - Register `rr_last_dma` updates on every GRANT of req (to 0) or dma (to 1).
  - When req and dma are both eligible, the channel not served last wins.
- Undefined:
  - req always beats dma.
  - `rr_last_dma` is not instantiated.
  - A continuous req stream can starve dma. This is the intended behaviour for CPU-only configs.

## Structure
- Shared package holds:
  - `llc_in_src_t` enum (2 bits) and the state enum.
  - `llc_req_in_t` and `llc_rsp_in_t`, which already exist there.
- One sub-module, `llc_input_prio`: combinational priority encoder.
  - Inputs: eligible mask, `rr_last_dma`.
  - Output: one-hot grant.
  - Instantiated once.
- FSM and payload registers stay in the top module.

## Test plan
- **rsp vs req:** rsp and req both valid in SCAN → rsp granted first: `rsp_ready_int` high in cycle 2, `sel_src`=`SRC_RSP`, `sel_rsp.addr`=0x1A0 as driven. req is served in the following transaction.
- **recall gating:** `recall_pending`=1 with only req valid → FSM stays in SCAN 10 cycles, `req_ready_int` never high. Drop `recall_pending` → req granted 2 cycles later.
- **round-robin on:** with `LLC_DMA_RR_EN`, req and dma continuously valid for 4 transactions → `sel_src` sequence REQ, DMA, REQ, DMA. Without the macro → REQ ×4.
- **back-pressure:** `sel_ready` held 0 for 5 cycles in FULL → `sel_valid` and `sel_req.line` stable all 5 cycles, all `ready_int`=0. One-cycle `sel_ready` → SCAN next cycle.
- **reset mid-op:** assert `rst` low during GRANT → `sel_valid`=0 and `ready_int`=0 immediately. After release, FSM is in SCAN and serves pending rst_tb with `sel_rst_tb`=1.
- **fast path:** back-to-back single-cycle handshakes with `sel_ready` tied 1 → one transaction every 3 cycles, no duplicate or lost messages over 100 random messages (scoreboard).

Source files
------------

// File: rtl/llc_input_select_pkg.sv
// Shared LLC input types: message payload structs, input-source and selector-state enums.
// The optional req/dma round-robin (macro LLC_DMA_RR_EN) is implemented in the users of this package.
package llc_input_select_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned COH_REQ_W = 3;
  localparam int unsigned COH_RSP_W = 2;
  localparam int unsigned HPROT_W   = 2;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned SRC_N     = 4;
  localparam int unsigned SRC_W     = 2;

  typedef struct packed {
    logic [COH_REQ_W-1:0] coh_msg;
    logic [HPROT_W-1:0]   hprot;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]    line;
    logic [ID_W-1:0]      req_id;
  } llc_req_in_t;

  typedef struct packed {
    logic [COH_RSP_W-1:0] coh_msg;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]    line;
    logic [ID_W-1:0]      req_id;
  } llc_rsp_in_t;

  // Enum value doubles as the bit index of that channel in valid/eligible/ready vectors.
  typedef enum logic [SRC_W-1:0] {
    SRC_RSP    = 2'd0,
    SRC_RST_TB = 2'd1,
    SRC_REQ    = 2'd2,
    SRC_DMA    = 2'd3
  } llc_in_src_t;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    GRANT = 2'd1,
    FULL  = 2'd2
  } llc_sel_state_t;

  // One-hot grant vector to source id; an all-zero vector maps to SRC_RSP.
  function automatic llc_in_src_t src_of(input logic [SRC_N-1:0] onehot);
    llc_in_src_t src;
    src = SRC_RSP;
    if (onehot[SRC_DMA])         src = SRC_DMA;
    else if (onehot[SRC_REQ])    src = SRC_REQ;
    else if (onehot[SRC_RST_TB]) src = SRC_RST_TB;
    return src;
  endfunction

endpackage

// File: rtl/llc_input_prio.sv
// Fixed-priority picker for the LLC input channels: rsp > rst_tb > (req vs dma).
// With LLC_DMA_RR_EN defined, req/dma contention alternates based on rr_last_dma.
module llc_input_prio
  import llc_input_select_pkg::*;
(
  input  logic [SRC_N-1:0] eligible,
  input  logic             rr_last_dma,
  output logic [SRC_N-1:0] grant_c
);

  logic dma_first_c;

`ifdef LLC_DMA_RR_EN
  // dma goes first only when req was the last of the pair to be served.
  assign dma_first_c = ~rr_last_dma;
`else
  logic unused_rr_last_dma;
  assign unused_rr_last_dma = rr_last_dma;
  assign dma_first_c        = 1'b0;
`endif

  always_comb begin
    grant_c = '0;
    if (eligible[SRC_RSP]) begin
      grant_c[SRC_RSP] = 1'b1;
    end else if (eligible[SRC_RST_TB]) begin
      grant_c[SRC_RST_TB] = 1'b1;
    end else if (eligible[SRC_REQ] && !(dma_first_c && eligible[SRC_DMA])) begin
      grant_c[SRC_REQ] = 1'b1;
    end else if (eligible[SRC_DMA]) begin
      grant_c[SRC_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/llc_input_select.sv
// Picks one of the four buffered LLC input channels per transaction and presents it on a
// registered valid/ready port. Optional req/dma round-robin under macro LLC_DMA_RR_EN.
module llc_input_select
  import llc_input_select_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        rsp_valid_int,
  output logic        rsp_ready_int,
  input  llc_rsp_in_t rsp_next,

  input  logic        rst_tb_valid_int,
  output logic        rst_tb_ready_int,
  input  logic        rst_tb_next,

  input  logic        req_valid_int,
  output logic        req_ready_int,
  input  llc_req_in_t req_next,

  input  logic        dma_req_valid_int,
  output logic        dma_req_ready_int,
  input  llc_req_in_t dma_req_next,

  input  logic        recall_pending,

  output logic        sel_valid,
  input  logic        sel_ready,
  output llc_in_src_t sel_src,
  output llc_req_in_t sel_req,
  output llc_rsp_in_t sel_rsp,
  output logic        sel_rst_tb
);

  llc_sel_state_t   state, state_d;
  llc_in_src_t      grant, grant_d;
  llc_in_src_t      sel_src_d;
  llc_req_in_t      sel_req_d;
  llc_rsp_in_t      sel_rsp_d;
  logic             sel_rst_tb_d;
  logic             sel_valid_d;
  logic [SRC_N-1:0] ready_q, ready_d;
  logic [SRC_N-1:0] valid_vec_c, eligible_c, win_c;
  logic             rr_last_dma_c;

  assign valid_vec_c = {dma_req_valid_int, req_valid_int, rst_tb_valid_int, rsp_valid_int};

  // A pending recall leaves only responses eligible so the core can make progress.
  assign eligible_c = recall_pending ? (valid_vec_c & SRC_N'(1)) : valid_vec_c;

`ifdef LLC_DMA_RR_EN
  logic rr_last_dma, rr_last_dma_d;
  assign rr_last_dma_c = rr_last_dma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_last_dma <= 1'b0;
    else      rr_last_dma <= rr_last_dma_d;
  end
`else
  assign rr_last_dma_c = 1'b0;
`endif

  llc_input_prio u_prio (
    .eligible    (eligible_c),
    .rr_last_dma (rr_last_dma_c),
    .grant_c     (win_c)
  );

  // Next-state, grant and registered-output values.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    ready_d      = '0;
    sel_valid_d  = sel_valid;
    sel_src_d    = sel_src;
    sel_req_d    = sel_req;
    sel_rsp_d    = sel_rsp;
    sel_rst_tb_d = sel_rst_tb;
`ifdef LLC_DMA_RR_EN
    rr_last_dma_d = rr_last_dma;
`endif
    case (state)
      SCAN: begin
        if (|eligible_c) begin
          grant_d = src_of(win_c);
          ready_d = win_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = SCAN;
`ifdef LLC_DMA_RR_EN
        if (grant == SRC_REQ)      rr_last_dma_d = 1'b0;
        else if (grant == SRC_DMA) rr_last_dma_d = 1'b1;
`endif
        // Upstream keeps a parked channel valid through GRANT; a drop here aborts quietly.
        if (valid_vec_c[grant]) begin
          state_d     = FULL;
          sel_valid_d = 1'b1;
          sel_src_d   = grant;
          case (grant)
            SRC_RSP:    sel_rsp_d    = rsp_next;
            SRC_RST_TB: sel_rst_tb_d = rst_tb_next;
            SRC_REQ:    sel_req_d    = req_next;
            SRC_DMA:    sel_req_d    = dma_req_next;
          endcase
        end
      end
      FULL: begin
        if (sel_ready) begin
          sel_valid_d = 1'b0;
          state_d     = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      grant      <= SRC_RSP;
      ready_q    <= '0;
      sel_valid  <= 1'b0;
      sel_src    <= SRC_RSP;
      sel_req    <= '0;
      sel_rsp    <= '0;
      sel_rst_tb <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      ready_q    <= ready_d;
      sel_valid  <= sel_valid_d;
      sel_src    <= sel_src_d;
      sel_req    <= sel_req_d;
      sel_rsp    <= sel_rsp_d;
      sel_rst_tb <= sel_rst_tb_d;
    end
  end

  assign rsp_ready_int     = ready_q[SRC_RSP];
  assign rst_tb_ready_int  = ready_q[SRC_RST_TB];
  assign req_ready_int     = ready_q[SRC_REQ];
  assign dma_req_ready_int = ready_q[SRC_DMA];

endmodule

// File: tb/tb_llc_input_select.sv
// Directed bench for llc_input_select: priority, recall gating, req/dma arbitration,
// back-pressure, mid-transaction reset and a 100-message fast-path scoreboard.
module tb_llc_input_select;
  import llc_input_select_pkg::*;

  logic        clk;
  logic        rst;
  logic        rsp_valid_int, rsp_ready_int;
  llc_rsp_in_t rsp_next;
  logic        rst_tb_valid_int, rst_tb_ready_int, rst_tb_next;
  logic        req_valid_int, req_ready_int;
  llc_req_in_t req_next;
  logic        dma_req_valid_int, dma_req_ready_int;
  llc_req_in_t dma_req_next;
  logic        recall_pending;
  logic        sel_valid, sel_ready, sel_rst_tb;
  llc_in_src_t sel_src;
  llc_req_in_t sel_req;
  llc_rsp_in_t sel_rsp;

  int n_checks = 0;
  int n_errors = 0;

  llc_req_in_t exp_req;
  llc_rsp_in_t exp_rsp;
  logic        exp_rst_tb;
  llc_in_src_t rr_exp [4];
  llc_req_in_t line_hold;

  llc_input_select dut (
    .clk               (clk),
    .rst               (rst),
    .rsp_valid_int     (rsp_valid_int),
    .rsp_ready_int     (rsp_ready_int),
    .rsp_next          (rsp_next),
    .rst_tb_valid_int  (rst_tb_valid_int),
    .rst_tb_ready_int  (rst_tb_ready_int),
    .rst_tb_next       (rst_tb_next),
    .req_valid_int     (req_valid_int),
    .req_ready_int     (req_ready_int),
    .req_next          (req_next),
    .dma_req_valid_int (dma_req_valid_int),
    .dma_req_ready_int (dma_req_ready_int),
    .dma_req_next      (dma_req_next),
    .recall_pending    (recall_pending),
    .sel_valid         (sel_valid),
    .sel_ready         (sel_ready),
    .sel_src           (sel_src),
    .sel_req           (sel_req),
    .sel_rsp           (sel_rsp),
    .sel_rst_tb        (sel_rst_tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] readies();
    return {dma_req_ready_int, req_ready_int, rst_tb_ready_int, rsp_ready_int};
  endfunction

  initial begin
    rst = 1'b0;
    rsp_valid_int = 1'b0; rst_tb_valid_int = 1'b0; req_valid_int = 1'b0; dma_req_valid_int = 1'b0;
    rsp_next = '0; rst_tb_next = 1'b0; req_next = '0; dma_req_next = '0;
    recall_pending = 1'b0; sel_ready = 1'b0;
    exp_req = '0; exp_rsp = '0; exp_rst_tb = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_sel_valid", 128'(sel_valid), 128'(0));
    chk("rst_ready", 128'(readies()), 128'(0));
    chk("rst_sel_src", 128'(sel_src), 128'(SRC_RSP));
    chk("rst_sel_req", 128'(sel_req), 128'(0));
    chk("rst_sel_rsp", 128'(sel_rsp), 128'(0));
    chk("rst_sel_rst_tb", 128'(sel_rst_tb), 128'(0));
    rst = 1'b1;
    tick();

    // rsp beats req; req served next
    rsp_next = '{coh_msg: 2'd1, addr: 32'h1A0, line: 64'hDEAD_BEEF_0000_0001, req_id: 4'd3};
    req_next = '{coh_msg: 3'd2, hprot: 2'd1, addr: 32'h2000, line: 64'h1111_2222_3333_4444, req_id: 4'd5};
    rsp_valid_int = 1'b1; req_valid_int = 1'b1;
    tick();
    chk("rr1_ready", 128'(readies()), 128'(4'b0001));
    tick();
    chk("rr1_sel_valid", 128'(sel_valid), 128'(1));
    chk("rr1_sel_src", 128'(sel_src), 128'(SRC_RSP));
    chk("rr1_rsp_addr", 128'(sel_rsp.addr), 128'(32'h1A0));
    chk("rr1_ready_low", 128'(readies()), 128'(0));
    rsp_valid_int = 1'b0; sel_ready = 1'b1;
    tick();
    chk("rr1_released", 128'(sel_valid), 128'(0));
    sel_ready = 1'b0;
    tick();
    chk("rr2_ready", 128'(readies()), 128'(4'b0100));
    tick();
    chk("rr2_sel_src", 128'(sel_src), 128'(SRC_REQ));
    chk("rr2_sel_req", 128'(sel_req), 128'(req_next));
    chk("rr2_rsp_held", 128'(sel_rsp.addr), 128'(32'h1A0));
    req_valid_int = 1'b0; sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;

    // Recall pending masks everything but rsp
    recall_pending = 1'b1; req_valid_int = 1'b1;
    req_next.line = 64'hCAFE_F00D_0000_0007;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("recall_req_ready", 128'(req_ready_int), 128'(0));
      chk("recall_sel_valid", 128'(sel_valid), 128'(0));
    end
    recall_pending = 1'b0;
    tick();
    chk("recall_grant", 128'(readies()), 128'(4'b0100));
    tick();
    chk("recall_sel_valid_on", 128'(sel_valid), 128'(1));
    chk("recall_sel_src", 128'(sel_src), 128'(SRC_REQ));
    line_hold = req_next;
    req_valid_int = 1'b0;
    req_next.line = 64'h0;

    // Back-pressure: FULL holds payload for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sel_valid", 128'(sel_valid), 128'(1));
      chk("bp_line", 128'(sel_req.line), 128'(line_hold.line));
      chk("bp_ready", 128'(readies()), 128'(0));
    end
    sel_ready = 1'b1;
    tick();
    chk("bp_release", 128'(sel_valid), 128'(0));
    sel_ready = 1'b0;

    // req vs dma arbitration; prime with a dma-only transaction
    sel_ready = 1'b1;
    dma_req_next = '{coh_msg: 3'd4, hprot: 2'd2, addr: 32'h3000, line: 64'h5555_6666_7777_8888, req_id: 4'd9};
    dma_req_valid_int = 1'b1;
    tick();
    chk("dma_prime_ready", 128'(readies()), 128'(4'b1000));
    tick();
    chk("dma_prime_src", 128'(sel_src), 128'(SRC_DMA));
    dma_req_valid_int = 1'b0;
    tick();
`ifdef LLC_DMA_RR_EN
    rr_exp = '{SRC_REQ, SRC_DMA, SRC_REQ, SRC_DMA};
`else
    rr_exp = '{SRC_REQ, SRC_REQ, SRC_REQ, SRC_REQ};
`endif
    req_valid_int = 1'b1; dma_req_valid_int = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk("arb_sel_valid", 128'(sel_valid), 128'(1));
      chk("arb_sel_src", 128'(sel_src), 128'(rr_exp[k]));
      tick();
    end
    req_valid_int = 1'b0; dma_req_valid_int = 1'b0;
    sel_ready = 1'b0;

    // Reset during GRANT drops the transaction
    rst_tb_next = 1'b1; rst_tb_valid_int = 1'b1;
    tick();
    chk("rmo_grant", 128'(readies()), 128'(4'b0010));
    #2 rst = 1'b0;
    #1;
    chk("rmo_sel_valid", 128'(sel_valid), 128'(0));
    chk("rmo_ready", 128'(readies()), 128'(0));
    chk("rmo_sel_src", 128'(sel_src), 128'(SRC_RSP));
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("rmo_regrant", 128'(readies()), 128'(4'b0010));
    tick();
    chk("rmo_src", 128'(sel_src), 128'(SRC_RST_TB));
    chk("rmo_rst_tb", 128'(sel_rst_tb), 128'(1));
    rst_tb_valid_int = 1'b0; sel_ready = 1'b1;
    tick();

    // Fast path: one message every 3 cycles, scoreboard against a payload model
    exp_req = '0; exp_rsp = '0; exp_rst_tb = 1'b1;
    for (int i = 0; i < 100; i++) begin
      llc_in_src_t ch;
      ch = llc_in_src_t'(2'($urandom_range(3, 0)));
      case (ch)
        SRC_RSP: begin
          rsp_next = '{coh_msg: 2'($urandom), addr: $urandom, line: {$urandom, $urandom}, req_id: 4'($urandom)};
          exp_rsp = rsp_next; rsp_valid_int = 1'b1;
        end
        SRC_RST_TB: begin
          rst_tb_next = 1'($urandom);
          exp_rst_tb = rst_tb_next; rst_tb_valid_int = 1'b1;
        end
        SRC_REQ: begin
          req_next = '{coh_msg: 3'($urandom), hprot: 2'($urandom), addr: $urandom, line: {$urandom, $urandom}, req_id: 4'($urandom)};
          exp_req = req_next; req_valid_int = 1'b1;
        end
        default: begin
          dma_req_next = '{coh_msg: 3'($urandom), hprot: 2'($urandom), addr: $urandom, line: {$urandom, $urandom}, req_id: 4'($urandom)};
          exp_req = dma_req_next; dma_req_valid_int = 1'b1;
        end
      endcase
      tick();
      chk("fp_ready", 128'(readies()), 128'(4'b0001 << ch));
      tick();
      chk("fp_sel_valid", 128'(sel_valid), 128'(1));
      chk("fp_sel_src", 128'(sel_src), 128'(ch));
      chk("fp_sel_req", 128'(sel_req), 128'(exp_req));
      chk("fp_sel_rsp", 128'(sel_rsp), 128'(exp_rsp));
      chk("fp_sel_rst_tb", 128'(sel_rst_tb), 128'(exp_rst_tb));
      rsp_valid_int = 1'b0; rst_tb_valid_int = 1'b0; req_valid_int = 1'b0; dma_req_valid_int = 1'b0;
      tick();
      chk("fp_gap", 128'(sel_valid), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
